seq_alu: RTL and testbench
==========================

# seq_alu

Multi-cycle 8-bit execute stage of the picoMIPS datapath, sitting directly downstream of the register file. It consumes the two register read operands plus an opcode and destination index, and computes the result (single-cycle logic ops or an iterative shift-add multiply). It then emits a one-cycle write-back strobe, destination index and result that drive the register file write port directly.

## Interface
- `WIDTH`, 8, operand/result width; the multiplier iterates `WIDTH` times.
- `clk`  in  1  clock, rising edge.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; accepted only when `busy`=0.
- `op`  in  3  operation code (`alu_op_t`).
- `a`  in  WIDTH  operand 1 (register read port 1).
- `b`  in  WIDTH  operand 2 (register read port 2 or immediate).
- `dest_in`  in  3  destination register index, latched with the request.
- `busy`  out  1  high while a multiply iterates.
- `wb_en`  out  1  one-cycle completion strobe; drives register-file write enable.
- `dest_out`  out  3  latched destination index; drives register-file write address.
- `result`  out  WIDTH  computed value; held until the next completion.
- `zero`  out  1  `result`==0, updated with `result`.
- `carry`  out  1  ADD carry-out / SUB no-borrow (`a`>=`b`); 0 for other ops.
- `illegal`  out  1  set at completion of an unsupported op; cleared at the next completion.

## Operation
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASSB (`result`=`b`), 110 MULL (low byte of unsigned `a`*`b`), 111 MULH (high byte).
- ADD/SUB wrap modulo 2^WIDTH. `carry` = bit WIDTH of the full-width sum/difference-plus-one.
- FSM states are IDLE, MUL and DONE.
  - IDLE: `start` latches `op`, `a`, `b` and `dest_in`. MUL ops go to MUL with counter=0. Other ops compute, register `result`/flags, and go to DONE.
  - MUL: each cycle is one shift-add step on a 2*WIDTH accumulator. The accumulator starts as {0, `b`}. If the LSB is 1, the high half gets `a` added with a carry bit; then the accumulator shifts right by 1. After `WIDTH` steps, select the low/high byte into `result` and go to DONE.
  - DONE: `wb_en`=1 for this single cycle. `start` here is accepted exactly as in IDLE (back-to-back issue). Otherwise go to IDLE.
- `busy` = (state==MUL). `start` while `busy` is ignored, and no state or latched operand changes.
- Operand inputs are sampled only at acceptance. Later changes to `a`/`b` do not affect an in-flight multiply.
- Outputs `result`, `zero`, `carry`, `illegal` and `dest_out` update only on entry to DONE.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `busy`=0, `wb_en`=0, `result`=0, `dest_out`=0, `zero`=1, `carry`=0, `illegal`=0, counter=0, accumulator=0.
- Reset mid-multiply aborts immediately. No `wb_en` is produced for the aborted request.
- Non-MUL latency: `start` sampled at edge N, `wb_en`/`result` valid in cycle N+1.
- MUL latency: `start` at edge N, `busy` in cycles N+1..N+WIDTH, `wb_en` in cycle N+WIDTH+1.
- Max throughput: one non-MUL op per cycle when `start` is held high (DONE→DONE).
- The register file captures `result` at the edge ending the `wb_en` cycle.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MULL/MULH run as above and `illegal` is always 0.
- Undefined: multiplier datapath, counter and MUL state are not compiled in. Opcodes 110/111 complete with non-MUL latency, with `result`=0, `zero`=1, `carry`=0 and `illegal`=1.

## Structure
- Package `seq_alu_pkg` holds:
  - `alu_op_t` enum (3-bit, the eight opcodes above);
  - `alu_state_t` enum (IDLE, MUL, DONE);
  - `ALU_W`=8 default width constant.
- One sub-module, `shift_add_mul`: accumulator, iteration counter and `step`/`load`/`last` signals. It is instantiated only under `SEQ_ALU_MUL_EN`. `seq_alu` keeps the FSM, the combinational ops and the output registers.

## Test plan
- Reset with `start`=1 held → all outputs at reset values. After release, first `start` with ADD a=200, b=100 → next cycle `wb_en`=1, `result`=44, `carry`=1, `zero`=0.
- Back-to-back, `start` held: SUB 5-5, then XOR 0xF0^0x0F, `dest_in` 3 then 6 → `wb_en` on two consecutive cycles. First: `result`=0, `zero`=1, `carry`=1, `dest_out`=3. Second: `result`=0xFF, `dest_out`=6.
- MULH a=0xC8, b=0x64 (product 0x4E20) → `busy` for 8 cycles, then `wb_en` with `result`=0x4E. MULL with the same operands → `result`=0x20.
- `start` with ADD during a multiply; `a` changed mid-multiply → ADD ignored, and the multiply result uses the originally latched operands.
- Assert `n_reset` at the 4th MUL cycle → `busy`=0 and `wb_en`=0 immediately. No write-back follows. The next ADD 1+1 yields 2.
- Build without `SEQ_ALU_MUL_EN`, issue MULL 3*4 → `wb_en` after 1 cycle with `result`=0, `illegal`=1. A following OR 0x0A|0x05 → `result`=0x0F, `illegal`=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types and constants for the picoMIPS sequential ALU.
// Contents: alu_op_t (3-bit opcodes), alu_state_t (FSM states),
//           ALU_W (default datapath width), is_mul_op() helper.
package seq_alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_PASSB = 3'b101,
        OP_MULL  = 3'b110,
        OP_MULH  = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // Both multiply opcodes share the 11x prefix.
    function automatic logic is_mul_op(alu_op_t op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: request/write-back bundle between register file and seq_alu.
// Request (master drives): start, op, a, b, dest_in.
// Response (slave drives): busy, wb_en, dest_out, result, zero, carry, illegal.
interface seq_alu_if
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
);
    logic             start;
    alu_op_t          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       dest_in;
    logic             busy;
    logic             wb_en;
    logic [2:0]       dest_out;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             illegal;

    modport master (
        output start, op, a, b, dest_in,
        input  busy, wb_en, dest_out, result, zero, carry, illegal
    );

    modport slave (
        input  start, op, a, b, dest_in,
        output busy, wb_en, dest_out, result, zero, carry, illegal
    );
endinterface

// File: rtl/seq_alu_shift_add_mul.sv
// shift_add_mul: iterative unsigned shift-add multiplier, one step per cycle.
// Ports: clk, n_reset (async, active-low), load (capture a/b, clear counter),
//        step (advance one iteration), a/b operands, last (this step is the
//        final one), prod (accumulator value after the current step).
module shift_add_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   a_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     hi_sum;

    // High half plus (optionally) the multiplicand, keeping the carry bit
    // so the right shift brings it back into the top of the accumulator.
    assign hi_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? a_q : '0};
    assign prod   = {hi_sum, acc[WIDTH-1:1]};
    assign last   = step && cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc <= '0;
            a_q <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, b};
            a_q <= a;
            cnt <= '0;
        end else if (step) begin
            acc <= prod;
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute stage of the picoMIPS datapath.
// Ports: clk, n_reset (async assert, active-low), bus (seq_alu_if.slave):
//        start/op/a/b/dest_in request; busy, wb_en write-back strobe,
//        dest_out, result, zero, carry, illegal held until next completion.
// Build option: define SEQ_ALU_MUL_EN to include the shift-add multiplier;
// without it MULL/MULH complete in one cycle flagged illegal with result 0.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic        clk,
    input  logic        n_reset,
    seq_alu_if.slave    bus
);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_MUL  = ST_MUL;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]       state;
    logic             accept;
    logic             is_mul;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    assign accept = bus.start && state != S_MUL;
    assign is_mul = is_mul_op(bus.op);
    assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
    // a + ~b + 1: bit WIDTH is the no-borrow flag (a >= b).
    assign diff   = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH + 1)'(1);

    always_comb begin
        alu_res = bus.op == OP_ADD   ? sum[WIDTH-1:0]  :
                  bus.op == OP_SUB   ? diff[WIDTH-1:0] :
                  bus.op == OP_AND   ? bus.a & bus.b   :
                  bus.op == OP_OR    ? bus.a | bus.b   :
                  bus.op == OP_XOR   ? bus.a ^ bus.b   :
                  bus.op == OP_PASSB ? bus.b           : '0;
        alu_c   = bus.op == OP_ADD ? sum[WIDTH] :
                  bus.op == OP_SUB ? diff[WIDTH] : 1'b0;
    end

    assign bus.busy  = state == S_MUL;
    assign bus.wb_en = state == S_DONE;

`ifdef SEQ_ALU_MUL_EN
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_prod;
    logic               op_hi_q;
    logic [2:0]         dest_q;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .n_reset (n_reset),
        .load    (accept && is_mul),
        .step    (state == S_MUL),
        .a       (bus.a),
        .b       (bus.b),
        .last    (mul_last),
        .prod    (mul_prod)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= S_IDLE;
            op_hi_q      <= 1'b0;
            dest_q       <= '0;
            bus.result   <= '0;
            bus.dest_out <= '0;
            bus.zero     <= 1'b1;
            bus.carry    <= 1'b0;
            bus.illegal  <= 1'b0;
        end else if (accept && is_mul) begin
            state   <= S_MUL;
            op_hi_q <= bus.op == OP_MULH;
            dest_q  <= bus.dest_in;
        end else if (accept) begin
            state        <= S_DONE;
            bus.result   <= alu_res;
            bus.dest_out <= bus.dest_in;
            bus.zero     <= alu_res == '0;
            bus.carry    <= alu_c;
            bus.illegal  <= 1'b0;
        end else if (state == S_MUL) begin
            if (mul_last) begin
                state        <= S_DONE;
                bus.result   <= op_hi_q ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];
                bus.dest_out <= dest_q;
                bus.zero     <= (op_hi_q ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0]) == '0;
                bus.carry    <= 1'b0;
                bus.illegal  <= 1'b0;
            end
        end else begin
            state <= S_IDLE;
        end
    end
`else
    // No multiplier: MUL opcodes fall through the combinational path
    // (alu_res = 0) and are reported as illegal.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= S_IDLE;
            bus.result   <= '0;
            bus.dest_out <= '0;
            bus.zero     <= 1'b1;
            bus.carry    <= 1'b0;
            bus.illegal  <= 1'b0;
        end else if (accept) begin
            state        <= S_DONE;
            bus.result   <= alu_res;
            bus.dest_out <= bus.dest_in;
            bus.zero     <= alu_res == '0;
            bus.carry    <= alu_c;
            bus.illegal  <= is_mul;
        end else begin
            state <= S_IDLE;
        end
    end
`endif
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu (both build options).
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    seq_alu_if #(.WIDTH(8)) bus ();

    seq_alu #(.WIDTH(8)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_t op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.dest_in = d;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        issue(OP_ADD, 8'd9, 8'd9, 3'd5);
        tick();
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL rst_wb_en got=%0b exp=0", bus.wb_en); end
        checks++; if (bus.result !== 8'd0) begin failures++; $display("FAIL rst_result got=%0h exp=0", bus.result); end
        checks++; if (bus.dest_out !== 3'd0) begin failures++; $display("FAIL rst_dest got=%0d exp=0", bus.dest_out); end
        checks++; if (bus.zero !== 1'b1) begin failures++; $display("FAIL rst_zero got=%0b exp=1", bus.zero); end
        checks++; if (bus.carry !== 1'b0) begin failures++; $display("FAIL rst_carry got=%0b exp=0", bus.carry); end
        checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%0b exp=0", bus.illegal); end
        bus.start = 1'b0;
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_add();
        issue(OP_ADD, 8'd200, 8'd100, 3'd1);
        tick();
        bus.start = 1'b0;
        checks++; if (bus.wb_en !== 1'b1) begin failures++; $display("FAIL add_wb_en got=%0b exp=1", bus.wb_en); end
        checks++; if (bus.result !== 8'd44) begin failures++; $display("FAIL add_result got=%0d exp=44", bus.result); end
        checks++; if (bus.carry !== 1'b1) begin failures++; $display("FAIL add_carry got=%0b exp=1", bus.carry); end
        checks++; if (bus.zero !== 1'b0) begin failures++; $display("FAIL add_zero got=%0b exp=0", bus.zero); end
        checks++; if (bus.dest_out !== 3'd1) begin failures++; $display("FAIL add_dest got=%0d exp=1", bus.dest_out); end
        tick();
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL add_wb_drop got=%0b exp=0", bus.wb_en); end
        checks++; if (bus.result !== 8'd44) begin failures++; $display("FAIL add_hold got=%0d exp=44", bus.result); end
    endtask

    task automatic test_back_to_back();
        issue(OP_SUB, 8'd5, 8'd5, 3'd3);
        tick();
        issue(OP_XOR, 8'hF0, 8'h0F, 3'd6);
        checks++; if (bus.wb_en !== 1'b1) begin failures++; $display("FAIL b2b_wb1 got=%0b exp=1", bus.wb_en); end
        checks++; if (bus.result !== 8'h00) begin failures++; $display("FAIL b2b_sub_result got=%0h exp=0", bus.result); end
        checks++; if (bus.zero !== 1'b1) begin failures++; $display("FAIL b2b_sub_zero got=%0b exp=1", bus.zero); end
        checks++; if (bus.carry !== 1'b1) begin failures++; $display("FAIL b2b_sub_carry got=%0b exp=1", bus.carry); end
        checks++; if (bus.dest_out !== 3'd3) begin failures++; $display("FAIL b2b_dest1 got=%0d exp=3", bus.dest_out); end
        tick();
        bus.start = 1'b0;
        checks++; if (bus.wb_en !== 1'b1) begin failures++; $display("FAIL b2b_wb2 got=%0b exp=1", bus.wb_en); end
        checks++; if (bus.result !== 8'hFF) begin failures++; $display("FAIL b2b_xor_result got=%0h exp=ff", bus.result); end
        checks++; if (bus.dest_out !== 3'd6) begin failures++; $display("FAIL b2b_dest2 got=%0d exp=6", bus.dest_out); end
        checks++; if (bus.carry !== 1'b0) begin failures++; $display("FAIL b2b_xor_carry got=%0b exp=0", bus.carry); end
        tick();
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL b2b_wb_drop got=%0b exp=0", bus.wb_en); end
        issue(OP_SUB, 8'd3, 8'd5, 3'd2);
        tick();
        bus.start = 1'b0;
        checks++; if (bus.result !== 8'hFE) begin failures++; $display("FAIL sub_borrow_result got=%0h exp=fe", bus.result); end
        checks++; if (bus.carry !== 1'b0) begin failures++; $display("FAIL sub_borrow_carry got=%0b exp=0", bus.carry); end
        tick();
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic test_mul();
        logic [7:0] exp_r [2] = '{8'h4E, 8'h20};
        alu_op_t    ops [2] = '{OP_MULH, OP_MULL};
        for (int k = 0; k < 2; k++) begin
            issue(ops[k], 8'hC8, 8'h64, 3'd5);
            tick();
            bus.start = 1'b0;
            for (int i = 0; i < 8; i++) begin
                checks++; if (bus.busy !== 1'b1 || bus.wb_en !== 1'b0) begin failures++; $display("FAIL mul_busy k=%0d i=%0d busy=%0b wb=%0b exp busy=1 wb=0", k, i, bus.busy, bus.wb_en); end
                tick();
            end
            checks++; if (bus.wb_en !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL mul_done k=%0d wb=%0b busy=%0b exp wb=1 busy=0", k, bus.wb_en, bus.busy); end
            checks++; if (bus.result !== exp_r[k]) begin failures++; $display("FAIL mul_result k=%0d got=%0h exp=%0h", k, bus.result, exp_r[k]); end
            checks++; if (bus.dest_out !== 3'd5 || bus.illegal !== 1'b0 || bus.carry !== 1'b0) begin failures++; $display("FAIL mul_flags k=%0d dest=%0d ill=%0b c=%0b exp 5/0/0", k, bus.dest_out, bus.illegal, bus.carry); end
            tick();
        end
    endtask

    task automatic test_mul_ignore();
        issue(OP_MULL, 8'h0F, 8'h03, 3'd2);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) issue(OP_ADD, 8'hFF, 8'h01, 3'd7);
            if (i == 3) begin bus.start = 1'b0; bus.a = 8'h55; end
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ign_busy i=%0d got=%0b exp=1", i, bus.busy); end
            tick();
        end
        checks++; if (bus.wb_en !== 1'b1) begin failures++; $display("FAIL ign_wb got=%0b exp=1", bus.wb_en); end
        checks++; if (bus.result !== 8'h2D) begin failures++; $display("FAIL ign_result got=%0h exp=2d", bus.result); end
        checks++; if (bus.dest_out !== 3'd2) begin failures++; $display("FAIL ign_dest got=%0d exp=2", bus.dest_out); end
        tick();
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL ign_extra_wb got=%0b exp=0", bus.wb_en); end
    endtask

    task automatic test_abort();
        int wb_seen = 0;
        issue(OP_MULL, 8'h07, 8'h09, 3'd4);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        n_reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.wb_en !== 1'b0) begin failures++; $display("FAIL abort_wb got=%0b exp=0", bus.wb_en); end
        tick();
        n_reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.wb_en === 1'b1) wb_seen++;
            tick();
        end
        checks++; if (wb_seen != 0) begin failures++; $display("FAIL abort_no_wb got=%0d exp=0", wb_seen); end
        issue(OP_ADD, 8'd1, 8'd1, 3'd1);
        tick();
        bus.start = 1'b0;
        checks++; if (bus.wb_en !== 1'b1 || bus.result !== 8'd2) begin failures++; $display("FAIL abort_add wb=%0b result=%0d exp wb=1 result=2", bus.wb_en, bus.result); end
        tick();
    endtask
`else
    task automatic test_no_mul();
        issue(OP_MULL, 8'd3, 8'd4, 3'd2);
        tick();
        bus.start = 1'b0;
        checks++; if (bus.wb_en !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL nomul_wb wb=%0b busy=%0b exp wb=1 busy=0", bus.wb_en, bus.busy); end
        checks++; if (bus.result !== 8'd0) begin failures++; $display("FAIL nomul_result got=%0h exp=0", bus.result); end
        checks++; if (bus.illegal !== 1'b1) begin failures++; $display("FAIL nomul_illegal got=%0b exp=1", bus.illegal); end
        checks++; if (bus.zero !== 1'b1 || bus.carry !== 1'b0) begin failures++; $display("FAIL nomul_flags zero=%0b carry=%0b exp 1/0", bus.zero, bus.carry); end
        tick();
        checks++; if (bus.illegal !== 1'b1) begin failures++; $display("FAIL nomul_illegal_hold got=%0b exp=1", bus.illegal); end
        issue(OP_OR, 8'h0A, 8'h05, 3'd3);
        tick();
        bus.start = 1'b0;
        checks++; if (bus.result !== 8'h0F) begin failures++; $display("FAIL nomul_or_result got=%0h exp=0f", bus.result); end
        checks++; if (bus.illegal !== 1'b0) begin failures++; $display("FAIL nomul_or_illegal got=%0b exp=0", bus.illegal); end
        tick();
        issue(OP_AND, 8'hC3, 8'h5A, 3'd1);
        tick();
        issue(OP_PASSB, 8'h11, 8'h3C, 3'd7);
        checks++; if (bus.result !== 8'h42) begin failures++; $display("FAIL and_result got=%0h exp=42", bus.result); end
        tick();
        bus.start = 1'b0;
        checks++; if (bus.result !== 8'h3C || bus.dest_out !== 3'd7) begin failures++; $display("FAIL passb result=%0h dest=%0d exp 3c/7", bus.result, bus.dest_out); end
        tick();
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.op = OP_ADD;
        bus.a = '0;
        bus.b = '0;
        bus.dest_in = '0;
        test_reset();
        test_add();
        test_back_to_back();
`ifdef SEQ_ALU_MUL_EN
        test_mul();
        test_mul_ignore();
        test_abort();
`else
        test_no_mul();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
